// File: rtl/sd_spi_router.sv
// rtl/sd_spi_router.sv - routes the core SPI master to the physical SD card or one of NCH virtual image slots
module sd_spi_router #(
  parameter int NCH         = 2,
  parameter int RST_PULSE   = 10000000,
  parameter int ACT_TIMEOUT = 1000000,
  parameter int CW          = 24,
  localparam int SW         = $clog2(NCH + 1)
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic [NCH-1:0] img_mounted,
  input  logic [NCH-1:0] img_nz,
  input  logic           spi_sck,
  input  logic           spi_mosi,
  input  logic           spi_cs_n,
  output logic           spi_miso,
  input  logic           SD_MISO,
  output logic           SD_SCK,
  output logic           SD_MOSI,
  output logic           SD_CS,
  input  logic [NCH-1:0] vsd_miso,
  output logic           vsd_sck,
  output logic           vsd_mosi,
  output logic [NCH-1:0] vsd_ss_n,
  output logic [SW-1:0]  sel,
  output logic           reset_img,
  output logic           act_phys,
  output logic           act_virt
);

  logic [SW-1:0] pend;
  logic          pend_v;
  logic [CW-1:0] rst_cnt;
  logic [CW-1:0] act_cnt;
  logic          act;
  logic          mosi_q;
  logic          miso_q;

  logic          ev;
  logic [SW-1:0] kidx;
  logic [SW-1:0] eff;
  logic          cand_v;
  logic [SW-1:0] cand;

  // Descending scan so the lowest set strobe index is the one left in kidx.
  always_comb begin
    ev   = 1'b0;
    kidx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (img_mounted[i]) begin
        ev   = 1'b1;
        kidx = SW'(i);
      end
    end
    eff    = pend_v ? pend : sel;
    cand   = '0;
    cand_v = 1'b0;
    if (img_nz[kidx]) begin
      cand   = kidx + SW'(1);
      cand_v = 1'b1;
    end else if (eff == kidx + SW'(1)) begin
      cand_v = 1'b1;
    end
  end

  // Target only moves while chip-select is idle; otherwise the request waits in pend.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (ev && cand_v) begin
      if (spi_cs_n) begin
        sel    <= cand;
        pend_v <= 1'b0;
      end else begin
        pend   <= cand;
        pend_v <= 1'b1;
      end
    end else if (spi_cs_n && pend_v) begin
      sel    <= pend;
      pend_v <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt   <= '0;
      reset_img <= 1'b0;
    end else if (ev) begin
      rst_cnt   <= CW'(RST_PULSE);
      reset_img <= 1'b1;
    end else if (rst_cnt != '0) begin
      rst_cnt <= rst_cnt - CW'(1);
    end else begin
      reset_img <= 1'b0;
    end
  end

  always_comb begin
    SD_CS    = (sel != '0) | spi_cs_n;
    SD_SCK   = spi_sck & ~SD_CS;
    SD_MOSI  = spi_mosi & ~SD_CS;
    vsd_sck  = spi_sck;
    vsd_mosi = spi_mosi;
    spi_miso = SD_MISO;
    for (int i = 0; i < NCH; i++) begin
      vsd_ss_n[i] = (sel != SW'(i + 1)) | spi_cs_n;
      if (sel == SW'(i + 1)) spi_miso = vsd_miso[i];
    end
  end

  // Any edge on either data line restarts the saturating idle counter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mosi_q  <= 1'b0;
      miso_q  <= 1'b0;
      act_cnt <= CW'(ACT_TIMEOUT);
      act     <= 1'b0;
    end else begin
      mosi_q <= spi_mosi;
      miso_q <= spi_miso;
      act    <= (act_cnt < CW'(ACT_TIMEOUT));
      if ((spi_mosi != mosi_q) || (spi_miso != miso_q))
        act_cnt <= '0;
      else if (act_cnt < CW'(ACT_TIMEOUT))
        act_cnt <= act_cnt + CW'(1);
    end
  end

  assign act_virt = act & (sel != '0);
  assign act_phys = act & (sel == '0);

endmodule

// File: tb/tb_sd_spi_router.sv
// tb/tb_sd_spi_router.sv - directed self-checking bench for sd_spi_router
module tb_sd_spi_router;
  localparam int NCH = 2;
  localparam int SW  = $clog2(NCH + 1);

  logic           clk_sys = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] img_mounted;
  logic [NCH-1:0] img_nz;
  logic           spi_sck, spi_mosi, spi_cs_n, spi_miso;
  logic           SD_MISO, SD_SCK, SD_MOSI, SD_CS;
  logic [NCH-1:0] vsd_miso, vsd_ss_n;
  logic           vsd_sck, vsd_mosi;
  logic [SW-1:0]  sel;
  logic           reset_img, act_phys, act_virt;

  int checks = 0;
  int errors = 0;

  sd_spi_router #(.NCH(NCH), .RST_PULSE(20), .ACT_TIMEOUT(8), .CW(24)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .img_mounted(img_mounted), .img_nz(img_nz),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
    .SD_MISO(SD_MISO), .SD_SCK(SD_SCK), .SD_MOSI(SD_MOSI), .SD_CS(SD_CS),
    .vsd_miso(vsd_miso), .vsd_sck(vsd_sck), .vsd_mosi(vsd_mosi), .vsd_ss_n(vsd_ss_n),
    .sel(sel), .reset_img(reset_img), .act_phys(act_phys), .act_virt(act_virt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Single-cycle strobe, applied just after an edge and sampled one edge later.
  task automatic strobe(input logic [NCH-1:0] m, input logic [NCH-1:0] nz);
    img_mounted = m;
    img_nz      = nz;
    step();
    img_mounted = '0;
    img_nz      = '0;
  endtask

  task automatic pulse_len(output int n);
    n = 0;
    for (int i = 0; i < 60 && reset_img; i++) begin
      n++;
      step();
    end
  endtask

  int n;

  initial begin
    reset_n = 1'b0; img_mounted = '0; img_nz = '0;
    spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    SD_MISO = 1'b0; vsd_miso = '0;
    #22;
    check("reset_sel", 32'(sel), 0);
    check("reset_rst", 32'(reset_img), 0);
    reset_n = 1'b1;
    repeat (100) step();
    check("idle_sel", 32'(sel), 0);
    check("idle_rst", 32'(reset_img), 0);
    check("idle_act_phys", 32'(act_phys), 0);
    check("idle_act_virt", 32'(act_virt), 0);
    check("idle_sd_cs", 32'(SD_CS), 1);
    check("idle_vss", 32'(vsd_ss_n), 32'b11);

    strobe(2'b10, 2'b10);
    check("mount1_sel", 32'(sel), 2);
    pulse_len(n);
    check("mount1_pulse", 32'(n), 21);
    spi_cs_n = 1'b0; spi_sck = 1'b1; vsd_miso = 2'b10; SD_MISO = 1'b0;
    #1;
    check("s2_vss", 32'(vsd_ss_n), 32'b01);
    check("s2_sd_cs", 32'(SD_CS), 1);
    check("s2_sd_sck", 32'(SD_SCK), 0);
    check("s2_miso_hi", 32'(spi_miso), 1);
    vsd_miso = 2'b01;
    #1;
    check("s2_miso_lo", 32'(spi_miso), 0);
    spi_sck = 1'b0; vsd_miso = '0; spi_cs_n = 1'b1;
    step();

    strobe(2'b10, 2'b00);
    check("unmount_to_phys", 32'(sel), 0);
    pulse_len(n);
    spi_cs_n = 1'b0;
    strobe(2'b01, 2'b01);
    check("pend_a", 32'(sel), 0);
    step(); step();
    strobe(2'b10, 2'b10);
    check("pend_b", 32'(sel), 0);
    spi_mosi = 1'b1;
    #1;
    check("phys_sd_mosi", 32'(SD_MOSI), 1);
    check("phys_sd_cs", 32'(SD_CS), 0);
    repeat (5) step();
    check("pend_hold", 32'(sel), 0);
    spi_cs_n = 1'b1; spi_mosi = 1'b0;
    #1;
    check("pend_before_edge", 32'(sel), 0);
    step();
    check("pend_applied", 32'(sel), 2);
    pulse_len(n);

    strobe(2'b11, 2'b11);
    check("dual_sel", 32'(sel), 1);
    pulse_len(n);
    check("dual_pulse", 32'(n), 21);

    strobe(2'b01, 2'b00);
    check("unmount0_sel", 32'(sel), 0);
    pulse_len(n);
    strobe(2'b10, 2'b00);
    check("unmount1_sel", 32'(sel), 0);
    check("unmount1_rst", 32'(reset_img), 1);
    pulse_len(n);
    check("unmount1_pulse", 32'(n), 21);

    strobe(2'b01, 2'b01);
    repeat (30) step();
    check("act_quiet", 32'(act_virt), 0);
    spi_mosi = 1'b1;
    step();
    check("act_e0", 32'(act_virt), 0);
    step();
    check("act_e1", 32'(act_virt), 1);
    check("act_phys_off", 32'(act_phys), 0);
    n = 0;
    for (int i = 0; i < 40 && act_virt; i++) begin
      n++;
      step();
    end
    check("act_len", 32'(n), 8);
    check("act_end_phys", 32'(act_phys), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_spi_router.md
Name: sd_spi_router

Overview:
- Routes the core's single SPI master to one of NCH+1 card targets:
  - target 0 is the physical SD pins;
  - targets 1..NCH are virtual image slots served by sd_card instances.
- Target selection follows image mount events from hps_io.
- Generates a stretched cold-reset request whenever an image is mounted or unmounted.
- Provides separate physical and virtual activity indicators for the LEDs.
- Generalises the single-slot SD mux logic in the top level to NCH slots.
- Adds transaction-safe switching: the target never changes while chip-select is active.

Parameters:
- NCH, 2, number of virtual image slots (1..7)
- RST_PULSE, 10000000, cycles added to the reset_img pulse after the mount strobe cycle
- ACT_TIMEOUT, 1000000, cycles an activity indicator stays on after the last line toggle
- CW, 24, width of the internal counters; must hold both RST_PULSE and ACT_TIMEOUT

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- img_mounted  in  NCH  per-slot single-cycle mount strobe
- img_nz  in  NCH  per slot: image size nonzero, valid while img_mounted is high
- spi_sck  in  1  core SPI clock
- spi_mosi  in  1  core SPI data out
- spi_cs_n  in  1  core SPI chip select
- spi_miso  out  1  routed data back to the core
- SD_MISO  in  1  physical card data
- SD_SCK  out  1  physical card clock
- SD_MOSI  out  1  physical card data out
- SD_CS  out  1  physical card select, active low
- vsd_miso  in  NCH  virtual slot data
- vsd_sck  out  1  shared virtual clock
- vsd_mosi  out  1  shared virtual data out
- vsd_ss_n  out  NCH  per-slot virtual select, active low
- sel  out  SW=$clog2(NCH+1)  current target (0 = physical)
- reset_img  out  1  cold-reset request
- act_phys  out  1  physical activity
- act_virt  out  1  virtual activity

Behaviour:
- Reset (reset_n low, asynchronous):
  - sel=0, pending invalid, reset_img=0.
  - Reset counter=0.
  - Activity counter=ACT_TIMEOUT, so act_phys=act_virt=0.
  - Previous-value registers for mosi/miso=0.
- Mount decode, each cycle:
  - Any img_mounted bit set → accepted event. Lowest set index k wins when several are set.
  - img_nz[k]=1 → candidate target k+1.
  - img_nz[k]=0 (unmount): candidate 0 if the effective target is k+1; otherwise no target change. Effective target = pending if valid, else sel.
- Target switch:
  - spi_cs_n=1 in the event cycle → sel takes the candidate on the next edge; pending is cleared.
  - spi_cs_n=0 → candidate stored in pending, overwriting any older pending.
  - First cycle with spi_cs_n=1 and pending valid → sel<=pending, pending cleared.
  - sel never changes while spi_cs_n=0.
- Reset pulse:
  - Any accepted event (unmount included) → reset_img<=1, counter<=RST_PULSE.
  - Otherwise, counter!=0 → decrement; counter==0 → reset_img<=0.
  - reset_img is high for exactly RST_PULSE+1 cycles after the strobe edge.
  - A retrigger reloads the counter.
- Routing (combinational from registered sel):
  - SD_CS = (sel!=0) | spi_cs_n.
  - SD_SCK = spi_sck & ~SD_CS.
  - SD_MOSI = spi_mosi & ~SD_CS.
  - vsd_ss_n[k] = (sel!=k+1) | spi_cs_n.
  - vsd_sck = spi_sck, vsd_mosi = spi_mosi.
  - spi_miso = SD_MISO when sel=0, else vsd_miso[sel-1].
- Activity:
  - Register spi_mosi and spi_miso every cycle.
  - Either differs from its registered copy → activity counter<=0.
  - Otherwise, counter<ACT_TIMEOUT → increment (saturates at ACT_TIMEOUT).
  - act = registered (counter<ACT_TIMEOUT).
  - act_virt = act & (sel!=0); act_phys = act & (sel==0).
- Out-of-range: sel is never loaded with a value greater than NCH.

Test Plan:
- Reset, then idle 100 cycles → sel=0, reset_img=0, act_phys=act_virt=0, SD_CS=1, all vsd_ss_n=1.
- img_mounted=2'b10, img_nz=2'b10, spi_cs_n=1 → next edge sel=2; reset_img high for RST_PULSE+1 cycles (bench sets RST_PULSE=20 → 21); spi_cs_n=0 → vsd_ss_n=2'b01, SD_CS=1, spi_miso follows vsd_miso[1].
- Hold spi_cs_n=0, strobe slot0 nz=1, then slot1 nz=1 three cycles later → sel stays 0 until spi_cs_n rises, then sel=2 one edge later.
- Same cycle img_mounted=2'b11, img_nz=2'b11 → sel=1, a single reset pulse.
- sel=1, strobe slot0 nz=0 → sel=0; then strobe slot1 nz=0 → sel stays 0, reset_img still pulses.
- ACT_TIMEOUT=8, sel=1, toggle spi_mosi once → act_virt rises 2 cycles later and stays high 8 cycles after the toggle; act_phys stays 0.
